// File: rtl/regfile_pkg.sv
// Shared constants for the multiport register file.
// Holds the default geometry (data width, address width, read-port count)
// and the fixed number of write ports.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;
  localparam int unsigned RF_NUM_WR = 2;

endpackage : regfile_pkg

// File: rtl/rf_scoreboard.sv
// Register-pending scoreboard: one pending bit per register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   iss_valid/iss_addr  issue strobe; sets pending for iss_addr
//   we0/waddr0          write port 0; clears pending for waddr0
//   we1/waddr1          write port 1; clears pending for waddr1
//   pend_nxt_c          combinational next-state pending vector (for read bypass)
//   any_pending         registered OR of the next-state pending vector
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   waddr0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   waddr1,
  output logic [NUM_REGS-1:0] pend_nxt_c,
  output logic                any_pending
);

  logic [NUM_REGS-1:0] pend_q;

  // Clears from writes first, then the issue set, so a same-cycle issue wins.
  always_comb begin
    pend_nxt_c = pend_q;
    if (we0) pend_nxt_c[waddr0] = 1'b0;
    if (we1) pend_nxt_c[waddr1] = 1'b0;
    if (iss_valid) pend_nxt_c[iss_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt_c[0] = 1'b0;
  end

  // Pending array and its summary flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      any_pending <= 1'b0;
    end else begin
      pend_q      <= pend_nxt_c;
      any_pending <= |pend_nxt_c;
    end
  end

endmodule : rf_scoreboard

// File: rtl/regfile_multiport.sv
// Multiport register file with two write ports, NUM_RD registered read ports,
// write-first bypass and a per-register pending scoreboard.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_en/rd_addr         per-port read enable and packed read addresses
//   rd_data/rd_pending    per-port registered read data and pending flag
//   we0/waddr0/wdata0     write port 0
//   we1/waddr1/wdata1     write port 1 (wins on same-address collision)
//   iss_valid/iss_addr    marks a register as having an outstanding producer
//   any_pending           registered OR of all pending bits
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = RF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     any_pending
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_nxt_c;
  logic                wr0_ok_c;
  logic                wr1_ok_c;

  // Writes aimed at the hardwired zero register are dropped.
  always_comb begin
    wr0_ok_c = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    wr1_ok_c = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  end

  // Storage; port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wr0_ok_c) regs_q[waddr0] <= wdata0;
      if (wr1_ok_c) regs_q[waddr1] <= wdata1;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_addr    (iss_addr),
    .we0         (wr0_ok_c),
    .waddr0      (waddr0),
    .we1         (wr1_ok_c),
    .waddr1      (waddr1),
    .pend_nxt_c  (pend_nxt_c),
    .any_pending (any_pending)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_c;
    logic [DATA_W-1:0] rdat_c;
    logic [DATA_W-1:0] data_q;
    logic              pend_q;

    assign ra_c = rd_addr[i*ADDR_W +: ADDR_W];

    // Write-first bypass with port 1 priority; zero register always reads 0.
    always_comb begin
      rdat_c = regs_q[ra_c];
      if (wr0_ok_c && (waddr0 == ra_c)) rdat_c = wdata0;
      if (wr1_ok_c && (waddr1 == ra_c)) rdat_c = wdata1;
      if ((ZERO_REG != 0) && (ra_c == '0)) rdat_c = '0;
    end

    // Read output registers; hold when the port is not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        pend_q <= 1'b0;
      end else if (rd_en[i]) begin
        data_q <= rdat_c;
        pend_q <= pend_nxt_c[ra_c];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data_q;
    assign rd_pending[i]               = pend_q;
  end

endmodule : regfile_multiport
